fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that drives the program ROM address and consumes its 24-bit words: 8-bit opcode plus 16-bit operand.
- ROM read is combinational; the fetched word is registered and handed to decode over a valid/ready handshake.
- Resolves JMP, CLL and RET locally using a hardware return stack.
- Takes redirects (for example, a taken JMA) from execute.
- Halts after issuing RST.

Parameters:
- WORD_WIDTH, 24, instruction word width.
- ADDR_BITS, 8, ROM address / PC width.
- OPCODE_BITS, 8, opcode field width (MSBs of word).
- STACK_DEPTH, 4, return stack entries.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  ADDR_BITS  ROM address; always equals current PC.
- rom_data  in  WORD_WIDTH  ROM read data, valid same cycle as rom_addr.
- instr  out  WORD_WIDTH  registered instruction to decode.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  decode accepts instr this cycle.
- redirect_valid  in  1  execute requests PC change.
- redirect_addr  in  ADDR_BITS  redirect target.
- halted  out  1  fetch stopped after RST.
- stack_err  out  1  sticky return-stack overflow/underflow.
- perf_fetched  out  16  fetched-instruction count (optional feature).
- perf_stalls  out  16  backpressure cycle count (optional feature).

Behaviour:
- Reset, asynchronous, rst_n=0:
  - pc=RESET_PC, instr=0, instr_valid=0, sp=0, stack_err=0, halted=0.
  - State FETCH; perf counters 0.
  - Reset mid-operation discards everything.
- States: FETCH, HALT.
- load = (state==FETCH) && (!instr_valid || instr_ready) && !redirect_valid.
- On load:
  - instr<=rom_data; instr_valid<=1 at the next edge. Latency is 1 cycle from PC to instr; throughput is 1 instruction/cycle.
  - next PC chosen by opcode of rom_data (opcode macros from the shared instruction header):
    - JMP: pc<=operand[ADDR_BITS-1:0].
    - CLL: push pc+1; pc<=operand[ADDR_BITS-1:0].
    - RET: pop; pc<=popped value.
    - RST: pc unchanged; state<=HALT; halted<=1.
    - All others, including JMA: pc<=pc+1, wrapping mod 2^ADDR_BITS.
  - JMP, CLL, RET and RST are still forwarded to decode.
- No load while instr_valid && !instr_ready: pc, instr and stack hold.
- redirect_valid has top priority:
  - pc<=redirect_addr; instr_valid<=0 (flush).
  - No push/pop that cycle, even if rom_data is CLL/RET.
  - state<=FETCH; halted<=0 (cancels a speculatively fetched RST).
- instr_ready with instr_valid=0 is ignored.
- Return stack:
  - Push at sp=STACK_DEPTH: entry dropped, stack_err<=1, jump still taken.
  - Pop at sp=0: stack_err<=1, pc<=pc+1.
  - stack_err clears only on reset.
- HALT: no loads. instr_valid drains normally on instr_ready. rom_addr holds the RST address.

Optional Feature:
FETCH_PERF_EN:
- Defined:
  - perf_fetched increments on each load.
  - perf_stalls increments on each cycle with instr_valid && !instr_ready.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: counter logic is absent; both ports are tied to 0.

Test Plan:
- Sequential: ROM {NOP,0},{LDI,5},{ST,1}, instr_ready=1 -> instr = words 0,1,2 on consecutive cycles; rom_addr 0,1,2,3.
- Backpressure: instr_ready=0 for 3 cycles after first valid -> instr and rom_addr frozen, no word lost or duplicated; perf_stalls=3 with FETCH_PERF_EN.
- Call/return: mem[1]={CLL,20}, mem[25]={RET,0} -> rom_addr 1,20..25,2; sp returns to 0; stack_err=0.
- Stack limits: STACK_DEPTH=4, five nested CLL -> stack_err=1, fifth target still fetched. Separately, a RET at sp=0 -> stack_err=1, pc+1.
- Redirect: redirect_valid=1, addr=8, on the same cycle rom_data={CLL,20} -> no push; instr_valid=0 next cycle; then word 8 fetched.
- Halt and reset: mem[2]={RST,0} -> halted=1 after RST issued, rom_addr stays 2. Assert rst_n=0 mid-run -> all outputs to reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the ROM address, registers fetched words for decode and
// resolves JMP/CLL/RET locally. Define FETCH_PERF_EN to build the fetch/stall counters.
module fetch_unit #(
    parameter int                    WORD_WIDTH  = 24,
    parameter int                    ADDR_BITS   = 8,
    parameter int                    OPCODE_BITS = 8,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [ADDR_BITS-1:0]  RESET_PC    = {ADDR_BITS{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [WORD_WIDTH-1:0] rom_data,
    output logic [WORD_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_BITS-1:0]  redirect_addr,
    output logic                  halted,
    output logic                  stack_err,
    output logic [15:0]           perf_fetched,
    output logic [15:0]           perf_stalls
);

    localparam int OPERAND_BITS = WORD_WIDTH - OPCODE_BITS;
    localparam int SP_BITS      = $clog2(STACK_DEPTH + 1);
    localparam int IDX_BITS     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // Opcode encodings shared with the instruction set definition.
    localparam logic [OPCODE_BITS-1:0] OP_JMP = OPCODE_BITS'(8'h10);
    localparam logic [OPCODE_BITS-1:0] OP_CLL = OPCODE_BITS'(8'h12);
    localparam logic [OPCODE_BITS-1:0] OP_RET = OPCODE_BITS'(8'h13);
    localparam logic [OPCODE_BITS-1:0] OP_RST = OPCODE_BITS'(8'hFF);

    localparam logic [SP_BITS-1:0]   SP_EMPTY = {SP_BITS{1'b0}};
    localparam logic [SP_BITS-1:0]   SP_ONE   = SP_BITS'(1);
    localparam logic [SP_BITS-1:0]   SP_FULL  = SP_BITS'(STACK_DEPTH);
    localparam logic [ADDR_BITS-1:0] PC_ONE   = ADDR_BITS'(1);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t                  state_r;
    logic [ADDR_BITS-1:0]    pc_r;
    logic [WORD_WIDTH-1:0]   instr_r;
    logic                    instr_valid_r;
    logic                    halted_r;
    logic                    stack_err_r;
    logic [SP_BITS-1:0]      sp_r;
    logic [ADDR_BITS-1:0]    stack_r [STACK_DEPTH];

    logic                    load_s;
    logic [OPCODE_BITS-1:0]  opcode_s;
    logic [ADDR_BITS-1:0]    target_s;
    logic [ADDR_BITS-1:0]    pc_inc_s;
    logic [ADDR_BITS-1:0]    pc_next_s;
    logic [IDX_BITS-1:0]     push_idx_s;
    logic [IDX_BITS-1:0]     top_idx_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    overflow_s;
    logic                    underflow_s;
    logic                    halt_s;
    logic                    unused_operand_s;

    assign rom_addr    = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign halted      = halted_r;
    assign stack_err   = stack_err_r;

    // Operand bits above the PC width never reach the fetch logic.
    assign unused_operand_s = ^rom_data[OPERAND_BITS-1:ADDR_BITS];

    // Load condition and next-PC selection from the word currently on the ROM bus.
    always_comb begin
        load_s      = (state_r == FETCH) && (!instr_valid_r || instr_ready) && !redirect_valid;
        opcode_s    = rom_data[WORD_WIDTH-1 -: OPCODE_BITS];
        target_s    = rom_data[ADDR_BITS-1:0];
        pc_inc_s    = pc_r + PC_ONE;
        push_idx_s  = IDX_BITS'(sp_r);
        top_idx_s   = IDX_BITS'(sp_r - SP_ONE);
        pc_next_s   = pc_inc_s;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        overflow_s  = 1'b0;
        underflow_s = 1'b0;
        halt_s      = 1'b0;
        case (opcode_s)
            OP_JMP: begin
                pc_next_s = target_s;
            end
            OP_CLL: begin
                pc_next_s = target_s;
                if (sp_r == SP_FULL) begin
                    overflow_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end
            OP_RET: begin
                if (sp_r == SP_EMPTY) begin
                    underflow_s = 1'b1;
                    pc_next_s   = pc_inc_s;
                end else begin
                    pop_s     = 1'b1;
                    pc_next_s = stack_r[top_idx_s];
                end
            end
            OP_RST: begin
                pc_next_s = pc_r;
                halt_s    = 1'b1;
            end
            default: begin
                pc_next_s = pc_inc_s;
            end
        endcase
    end

    // Fetch FSM, PC, instruction register and stack pointer; a redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            instr_r       <= {WORD_WIDTH{1'b0}};
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
            stack_err_r   <= 1'b0;
            sp_r          <= SP_EMPTY;
        end else if (redirect_valid) begin
            state_r       <= FETCH;
            pc_r          <= redirect_addr;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else if (load_s) begin
            instr_r       <= rom_data;
            instr_valid_r <= 1'b1;
            pc_r          <= pc_next_s;
            if (push_s) begin
                sp_r <= sp_r + SP_ONE;
            end else if (pop_s) begin
                sp_r <= sp_r - SP_ONE;
            end else begin
                sp_r <= sp_r;
            end
            if (overflow_s || underflow_s) begin
                stack_err_r <= 1'b1;
            end else begin
                stack_err_r <= stack_err_r;
            end
            if (halt_s) begin
                state_r  <= HALT;
                halted_r <= 1'b1;
            end else begin
                state_r  <= state_r;
                halted_r <= halted_r;
            end
        end else if (instr_valid_r && instr_ready) begin
            instr_valid_r <= 1'b0;
        end else begin
            instr_valid_r <= instr_valid_r;
        end
    end

    // Return address storage; written only on a non-overflowing CLL load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= {ADDR_BITS{1'b0}};
            end
        end else if (load_s && push_s) begin
            stack_r[push_idx_s] <= pc_inc_s;
        end else begin
            stack_r <= stack_r;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched_r;
    logic [15:0] perf_stalls_r;

    assign perf_fetched = perf_fetched_r;
    assign perf_stalls  = perf_stalls_r;

    // Saturating counters of loads and decode backpressure cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_r <= 16'h0000;
            perf_stalls_r  <= 16'h0000;
        end else begin
            if (load_s && (perf_fetched_r != 16'hFFFF)) begin
                perf_fetched_r <= perf_fetched_r + 16'h0001;
            end else begin
                perf_fetched_r <= perf_fetched_r;
            end
            if (instr_valid_r && !instr_ready && (perf_stalls_r != 16'hFFFF)) begin
                perf_stalls_r <= perf_stalls_r + 16'h0001;
            end else begin
                perf_stalls_r <= perf_stalls_r;
            end
        end
    end
`else
    assign perf_fetched = 16'h0000;
    assign perf_stalls  = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed program scenarios plus randomized traffic
// compared against a queue-based reference model of the fetch rules.
module tb_fetch_unit;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDI = 8'h01;
    localparam logic [7:0] OP_ST  = 8'h02;
    localparam logic [7:0] OP_JMP = 8'h10;
    localparam logic [7:0] OP_JMA = 8'h11;
    localparam logic [7:0] OP_CLL = 8'h12;
    localparam logic [7:0] OP_RET = 8'h13;
    localparam logic [7:0] OP_RST = 8'hFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic [23:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_addr = 8'h00;
    logic        halted;
    logic        stack_err;
    logic [15:0] perf_fetched;
    logic [15:0] perf_stalls;

    logic [23:0] mem [256];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  m_pc;
    logic [23:0] m_instr;
    logic        m_valid;
    logic        m_halted;
    logic        m_err;
    int          m_fetched;
    int          m_stalls;
    logic [7:0]  m_stack [$];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halted         (halted),
        .stack_err      (stack_err),
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls)
    );

    always #5 clk = ~clk;

    assign rom_data = mem[rom_addr];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] word(input logic [7:0] op, input logic [15:0] operand);
        return {op, operand};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) mem[i] = word(OP_NOP, 16'h0000);
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        m_instr = 24'h000000;
        m_valid = 1'b0;
        m_halted = 1'b0;
        m_err = 1'b0;
        m_fetched = 0;
        m_stalls = 0;
        m_stack.delete();
    endtask

    // One clock edge of the fetch rules, evaluated on the current inputs.
    task automatic model_edge();
        logic [23:0] w;
        logic [7:0]  op;
        logic [7:0]  nxt;
        if (m_valid && !instr_ready && m_stalls < 65535) m_stalls++;
        nxt = m_pc + 8'd1;
        if (redirect_valid) begin
            m_pc = redirect_addr;
            m_valid = 1'b0;
            m_halted = 1'b0;
        end else if (!m_halted && (!m_valid || instr_ready)) begin
            w = mem[m_pc];
            op = w[23:16];
            m_instr = w;
            m_valid = 1'b1;
            if (m_fetched < 65535) m_fetched++;
            if (op == OP_JMP) begin
                m_pc = w[7:0];
            end else if (op == OP_CLL) begin
                if (m_stack.size() < 4) m_stack.push_back(nxt);
                else m_err = 1'b1;
                m_pc = w[7:0];
            end else if (op == OP_RET) begin
                if (m_stack.size() == 0) begin
                    m_err = 1'b1;
                    m_pc = nxt;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end else if (op == OP_RST) begin
                m_halted = 1'b1;
            end else begin
                m_pc = nxt;
            end
        end else if (m_valid && instr_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_value("rom_addr", 32'(rom_addr), 32'(m_pc));
        check_value("instr_valid", 32'(instr_valid), 32'(m_valid));
        check_value("instr", 32'(instr), 32'(m_instr));
        check_value("halted", 32'(halted), 32'(m_halted));
        check_value("stack_err", 32'(stack_err), 32'(m_err));
`ifdef FETCH_PERF_EN
        check_value("perf_fetched", 32'(perf_fetched), 32'(m_fetched));
        check_value("perf_stalls", 32'(perf_stalls), 32'(m_stalls));
`else
        check_value("perf_fetched", 32'(perf_fetched), 32'h0);
        check_value("perf_stalls", 32'(perf_stalls), 32'h0);
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    logic [7:0] exp_addr [8];
    logic [7:0] ops [8];

    initial begin
        clear_rom();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Sequential fetch
        mem[0] = word(OP_NOP, 16'd0);
        mem[1] = word(OP_LDI, 16'd5);
        mem[2] = word(OP_ST, 16'd1);
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("seq_instr", 32'(instr), 32'(mem[i]));
            check_value("seq_addr", 32'(rom_addr), i + 1);
        end

        // Backpressure: decode stalls for three cycles
        do_reset();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("bp_instr", 32'(instr), 32'(mem[0]));
            check_value("bp_addr", 32'(rom_addr), 32'd1);
        end
        instr_ready = 1'b1;
        step();
        check_value("bp_next", 32'(instr), 32'(mem[1]));
`ifdef FETCH_PERF_EN
        check_value("bp_stalls", 32'(perf_stalls), 32'd3);
`endif

        // Call and return
        clear_rom();
        mem[1] = word(OP_CLL, 16'd20);
        mem[25] = word(OP_RET, 16'd0);
        exp_addr = '{8'd1, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd2};
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_value("call_addr", 32'(rom_addr), 32'(exp_addr[i]));
        end
        check_value("call_err", 32'(stack_err), 32'd0);

        // Five nested calls overflow a four-entry stack
        clear_rom();
        for (int i = 0; i < 5; i++) mem[i * 10] = word(OP_CLL, 16'((i + 1) * 10));
        do_reset();
        for (int i = 0; i < 6; i++) step();
        check_value("ovf_err", 32'(stack_err), 32'd1);
        check_value("ovf_target", 32'(rom_addr), 32'd51);

        // Return with an empty stack
        clear_rom();
        mem[0] = word(OP_RET, 16'd0);
        do_reset();
        step();
        check_value("unf_err", 32'(stack_err), 32'd1);
        check_value("unf_pc", 32'(rom_addr), 32'd1);

        // Redirect while a CLL sits on the ROM bus
        clear_rom();
        mem[0] = word(OP_CLL, 16'd20);
        mem[9] = word(OP_RET, 16'd0);
        do_reset();
        redirect_valid = 1'b1;
        redirect_addr = 8'd8;
        step();
        check_value("redir_valid", 32'(instr_valid), 32'd0);
        redirect_valid = 1'b0;
        step();
        check_value("redir_word", 32'(instr), 32'(mem[8]));
        step();
        check_value("redir_nopush", 32'(stack_err), 32'd1);

        // Halt on RST, then asynchronous reset while an instruction is pending
        clear_rom();
        mem[2] = word(OP_RST, 16'd0);
        do_reset();
        for (int i = 0; i < 3; i++) step();
        check_value("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) step();
        check_value("halt_addr", 32'(rom_addr), 32'd2);
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 8'd0;
        step();
        redirect_valid = 1'b0;
        step();
        check_value("pre_rst_valid", 32'(instr_valid), 32'd1);
        do_reset();

        // Randomized traffic
        ops = '{OP_NOP, OP_LDI, OP_ST, OP_JMP, OP_JMA, OP_CLL, OP_RET, OP_RST};
        for (int i = 0; i < 256; i++) begin
            int k;
            k = ($urandom_range(0, 19) == 0) ? 7 : $urandom_range(0, 6);
            mem[i] = word(ops[k], 16'($urandom));
        end
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
            redirect_addr = 8'($urandom);
            if ($urandom_range(0, 599) == 0) do_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
